// File: rtl/lift_scan_ctrl.sv
// Single-car lift controller using SCAN (elevator) scheduling over a pending-request bitmap.
// Optional emergency stop input is compiled in when LIFT_ESTOP_EN is defined.
module lift_scan_ctrl #(
    parameter int NUM_FLOORS    = 64,
    parameter int FLOOR_W       = 7,
    parameter int TRAVEL_CYCLES = 2,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
`ifdef LIFT_ESTOP_EN
    input  logic                  estop,
`endif
    output logic                  req_err,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  up,
    output logic                  down,
    output logic                  stop,
    output logic                  door,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]      TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0]      DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W+1)'(NUM_FLOORS);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      cur_floor_q, cur_floor_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    dir_up_q, dir_up_d;
    logic                    req_err_q, req_err_d;
`ifdef LIFT_ESTOP_EN
    logic                    halt_q, halt_d;
`endif

    logic                    accept;
    logic [FLOOR_W-1:0]      next_floor;
    logic [NUM_FLOORS-1:0]   accept_mask, cur_mask, next_mask;
    logic                    cur_hit, next_hit, any_above, any_below;
    logic                    scan_up, idle_up;

    // Request decode and floor-relative views of the pending bitmap
    always_comb begin
        accept      = req_valid && ({1'b0, req_floor} < FLOOR_LIMIT);
        next_floor  = (state_q == MOVE_UP) ? cur_floor_q + FLOOR_W'(1) : cur_floor_q - FLOOR_W'(1);
        accept_mask = '0;
        cur_mask    = '0;
        next_mask   = '0;
        cur_hit     = 1'b0;
        next_hit    = 1'b0;
        any_above   = 1'b0;
        any_below   = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            accept_mask[i] = accept && (FLOOR_W'(i) == req_floor);
            cur_mask[i]    = (FLOOR_W'(i) == cur_floor_q);
            next_mask[i]   = (FLOOR_W'(i) == next_floor);
            if (cur_mask[i] && pending_q[i])
                cur_hit = 1'b1;
            if (next_mask[i] && (pending_q[i] || accept_mask[i]))
                next_hit = 1'b1;
            if (pending_q[i] && (FLOOR_W'(i) > cur_floor_q))
                any_above = 1'b1;
            if (pending_q[i] && (FLOOR_W'(i) < cur_floor_q))
                any_below = 1'b1;
        end
        // SCAN keeps the last direction while work remains that way, otherwise reverses
        scan_up = dir_up_q ? any_above : !any_below;
        idle_up = any_above;
`ifdef LIFT_ESTOP_EN
        if (halt_q)
            idle_up = scan_up;
`endif
    end

    always_comb begin
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        pending_d   = pending_q | accept_mask;
        timer_d     = timer_q;
        dir_up_d    = dir_up_q;
        req_err_d   = req_valid && !accept;
`ifdef LIFT_ESTOP_EN
        halt_d      = halt_q;
        if (estop) begin
            state_d = IDLE;
            halt_d  = 1'b1;
        end else
`endif
        begin
            case (state_q)
                IDLE: begin
                    if (pending_q != '0) begin
                        if (cur_hit) begin
                            state_d   = DOOR_OPEN;
                            timer_d   = DOOR_LOAD;
                            pending_d = pending_d & ~cur_mask;
                        end else begin
                            state_d  = idle_up ? MOVE_UP : MOVE_DOWN;
                            dir_up_d = idle_up;
                            timer_d  = TRAVEL_LOAD;
                        end
`ifdef LIFT_ESTOP_EN
                        halt_d = 1'b0;
                    end else begin
                        halt_d = 1'b0;
`endif
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - TW'(1);
                    end else if ((state_q == MOVE_UP && cur_floor_q == TOP_FLOOR) ||
                                 (state_q == MOVE_DOWN && cur_floor_q == '0)) begin
                        state_d = IDLE;
                    end else begin
                        cur_floor_d = next_floor;
                        timer_d     = TRAVEL_LOAD;
                        if (next_hit) begin
                            state_d   = DOOR_OPEN;
                            timer_d   = DOOR_LOAD;
                            pending_d = pending_d & ~next_mask;
                        end
                    end
                end
                DOOR_OPEN: begin
                    // A call for the floor the door is already open at just extends the dwell
                    pending_d = pending_d & ~cur_mask;
                    if (accept && req_floor == cur_floor_q) begin
                        timer_d = DOOR_LOAD;
                    end else if (timer_q != '0) begin
                        timer_d = timer_q - TW'(1);
                    end else if (any_above || any_below) begin
                        state_d  = scan_up ? MOVE_UP : MOVE_DOWN;
                        dir_up_d = scan_up;
                        timer_d  = TRAVEL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_floor_q <= '0;
            pending_q   <= '0;
            timer_q     <= '0;
            dir_up_q    <= 1'b1;
            req_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_floor_q <= cur_floor_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
            dir_up_q    <= dir_up_d;
            req_err_q   <= req_err_d;
        end
    end

`ifdef LIFT_ESTOP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            halt_q <= 1'b0;
        else
            halt_q <= halt_d;
    end
`endif

    assign req_err   = req_err_q;
    assign cur_floor = cur_floor_q;
    assign pending   = pending_q;
    assign up        = (state_q == MOVE_UP);
    assign down      = (state_q == MOVE_DOWN);
    assign door      = (state_q == DOOR_OPEN);
    assign stop      = (state_q == IDLE) || (state_q == DOOR_OPEN);

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Self-checking bench for lift_scan_ctrl: directed scenarios plus randomized requests
// compared every cycle against a floor/bitmap-level behavioural model.
module tb_lift_scan_ctrl;

    localparam int NF = 64;
    localparam int FW = 7;
    localparam int TC = 2;
    localparam int DC = 4;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [FW-1:0] req_floor;
    logic          req_err, up, down, stop, door;
    logic [FW-1:0] cur_floor;
    logic [NF-1:0] pending;
`ifdef LIFT_ESTOP_EN
    logic          estop = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model: floor number, motion mode, per-floor request flags and countdowns
    int mFloor      = 0;
    int mMode       = M_IDLE;
    int mTravelLeft = 0;
    int mDoorLeft   = 0;
    bit mLastUp     = 1'b1;
    bit mErr        = 1'b0;
    bit mPend[NF];
    bit mSnap[NF];

    int upCnt, doorCnt, motionCnt, errCnt, n;
    bit seenDoor, prevDoor;
    int doorQ[$];

    lift_scan_ctrl #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_floor(req_floor),
`ifdef LIFT_ESTOP_EN
        .estop(estop),
`endif
        .req_err(req_err),
        .cur_floor(cur_floor),
        .up(up),
        .down(down),
        .stop(stop),
        .door(door),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit snapAbove();
        for (int i = mFloor + 1; i < NF; i++)
            if (mSnap[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit snapBelow();
        for (int i = 0; i < mFloor; i++)
            if (mSnap[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelStep();
        int rf;
        bit acc;
        bit goUp;
        if (reset) begin
            mFloor = 0; mMode = M_IDLE; mTravelLeft = 0; mDoorLeft = 0; mLastUp = 1'b1; mErr = 1'b0;
            foreach (mPend[i]) mPend[i] = 1'b0;
        end else begin
            rf   = int'(req_floor);
            acc  = req_valid && (rf < NF);
            mErr = req_valid && (rf >= NF);
            mSnap = mPend;
            if (acc) mPend[rf] = 1'b1;
            case (mMode)
                M_IDLE: begin
                    if (snapAbove() || snapBelow() || mSnap[mFloor]) begin
                        if (mSnap[mFloor]) begin
                            mPend[mFloor] = 1'b0; mMode = M_DOOR; mDoorLeft = DC;
                        end else begin
                            goUp = snapAbove();
                            mMode = goUp ? M_UP : M_DOWN; mLastUp = goUp; mTravelLeft = TC;
                        end
                    end
                end
                M_UP, M_DOWN: begin
                    mTravelLeft--;
                    if (mTravelLeft == 0) begin
                        mFloor = (mMode == M_UP) ? mFloor + 1 : mFloor - 1;
                        mTravelLeft = TC;
                        if (mPend[mFloor]) begin
                            mPend[mFloor] = 1'b0; mMode = M_DOOR; mDoorLeft = DC;
                        end
                    end
                end
                default: begin
                    mPend[mFloor] = 1'b0;
                    if (acc && rf == mFloor) begin
                        mDoorLeft = DC;
                    end else begin
                        mDoorLeft--;
                        if (mDoorLeft == 0) begin
                            if (mLastUp ? snapAbove() : snapBelow()) begin
                                mMode = mLastUp ? M_UP : M_DOWN; mTravelLeft = TC;
                            end else if (mLastUp ? snapBelow() : snapAbove()) begin
                                mLastUp = !mLastUp;
                                mMode = mLastUp ? M_UP : M_DOWN; mTravelLeft = TC;
                            end else begin
                                mMode = M_IDLE;
                            end
                        end
                    end
                end
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        modelStep();
    end

    // Every cycle, away from the active edge, the DUT must match the model
    initial forever begin
        logic [NF-1:0] ep;
        @(negedge clk);
        for (int i = 0; i < NF; i++) ep[i] = mPend[i];
        checkOutput("cur_floor", 128'(cur_floor), 128'(mFloor));
        checkOutput("up",        128'(up),        128'(mMode == M_UP));
        checkOutput("down",      128'(down),      128'(mMode == M_DOWN));
        checkOutput("door",      128'(door),      128'(mMode == M_DOOR));
        checkOutput("stop",      128'(stop),      128'(mMode == M_IDLE || mMode == M_DOOR));
        checkOutput("req_err",   128'(req_err),   128'(mErr));
        checkOutput("pending",   128'(pending),   128'(ep));
        checkOutput("up_down_exclusive", 128'(up & down), 128'(0));
    end

    task automatic applyStimulus(input int floorIdx);
        req_valid = 1'b1;
        req_floor = FW'(floorIdx);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_floor = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_cur_floor", 128'(cur_floor), 128'(0));
        checkOutput("rst_pending",   128'(pending),   128'(0));
        checkOutput("rst_stop",      128'(stop),      128'(1));
        checkOutput("rst_motion",    128'({up, down, door, req_err}), 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single request to floor 25 from rest
        applyStimulus(25);
        upCnt = 0; doorCnt = 0; seenDoor = 0; n = 0;
        while (n < 400 && !(seenDoor && !door)) begin
            if (up) upCnt++;
            if (door) begin doorCnt++; seenDoor = 1'b1; end
            @(negedge clk);
            n++;
        end
        checkOutput("A_done",       128'(n < 400), 128'(1));
        checkOutput("A_up_cycles",  128'(upCnt),   128'(25 * TC));
        checkOutput("A_door_cycles",128'(doorCnt), 128'(4));
        checkOutput("A_floor",      128'(cur_floor), 128'(25));
        checkOutput("A_idle",       128'({stop, up, down, door}), 128'(4'b1000));

        // Out-of-range floor is rejected with a single error pulse
        applyStimulus(70);
        errCnt = 0;
        repeat (4) begin
            if (req_err) errCnt++;
            @(negedge clk);
        end
        checkOutput("C_err_pulses", 128'(errCnt),  128'(1));
        checkOutput("C_pending",    128'(pending), 128'(0));

        // Moving up past 25 with calls at 3 and 37: 37 first, then reverse to 3
        doReset();
        applyStimulus(37);
        n = 0;
        while (n < 200 && cur_floor != FW'(25)) begin @(negedge clk); n++; end
        checkOutput("B_reach25", 128'(n < 200), 128'(1));
        checkOutput("B_moving_up", 128'(up), 128'(1));
        applyStimulus(3);
        applyStimulus(37);
        doorQ.delete();
        prevDoor = 1'b0; n = 0;
        while (n < 1000 && !(doorQ.size() >= 2 && pending == '0 && !door && stop)) begin
            if (door && !prevDoor) doorQ.push_back(int'(cur_floor));
            prevDoor = door;
            @(negedge clk);
            n++;
        end
        checkOutput("B_done",       128'(n < 1000),     128'(1));
        checkOutput("B_stops",      128'(doorQ.size()), 128'(2));
        checkOutput("B_first_stop", 128'(doorQ[0]),     128'(37));
        checkOutput("B_second_stop",128'(doorQ[1]),     128'(3));
        checkOutput("B_pending",    128'(pending),      128'(0));

        // Re-calling the current floor while the door is open extends the dwell
        applyStimulus(3);
        n = 0;
        while (n < 10 && !door) begin @(negedge clk); n++; end
        checkOutput("D_door_opened", 128'(door), 128'(1));
        repeat (2) @(negedge clk);
        applyStimulus(3);
        doorCnt = 0; motionCnt = 0; n = 0;
        while (n < 20 && door) begin
            doorCnt++;
            if (up || down) motionCnt++;
            @(negedge clk);
            n++;
        end
        checkOutput("D_door_cycles", 128'(doorCnt),   128'(4));
        checkOutput("D_no_motion",   128'(motionCnt), 128'(0));
        checkOutput("D_floor",       128'(cur_floor), 128'(3));

        // Reset in the middle of a trip toward floor 10
        doReset();
        applyStimulus(10);
        n = 0;
        while (n < 100 && cur_floor != FW'(5)) begin @(negedge clk); n++; end
        checkOutput("E_reach5", 128'(n < 100), 128'(1));
        #2 reset = 1'b1;
        #1;
        checkOutput("E_cur_floor", 128'(cur_floor), 128'(0));
        checkOutput("E_pending",   128'(pending),   128'(0));
        checkOutput("E_outputs",   128'({up, down, door, stop, req_err}), 128'(5'b00010));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Randomized traffic including bad floors, current-floor calls and a mid-run reset
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                req_valid = 1'b1;
                case ($urandom_range(0, 9))
                    0:       req_floor = FW'($urandom_range(64, 127));
                    1:       req_floor = FW'(mFloor);
                    default: req_floor = FW'($urandom_range(0, 63));
                endcase
            end else begin
                req_valid = 1'b0;
            end
            if (c == 1500) reset = 1'b1;
            if (c == 1502) reset = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        n = 0;
        while (n < 3000 && !(pending == '0 && stop && !door)) begin @(negedge clk); n++; end
        checkOutput("R_drained", 128'(n < 3000), 128'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lift_scan_ctrl.md
LIFT_SCAN_CTRL -- requirements
Module: lift_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 64: number of served floors, range 2..128.
REQ-002 SHALL have parameter FLOOR_W, default 7: floor index width; the condition 2^FLOOR_W >= NUM_FLOORS SHALL hold.
REQ-003 SHALL have parameter TRAVEL_CYCLES, default 2: clock cycles to move one floor, minimum 1.
REQ-004 SHALL have parameter DOOR_CYCLES, default 4: clock cycles the door stays open, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, 1 bit: a floor request is present this cycle.
REQ-008 SHALL have port req_floor, input, FLOOR_W bits: the requested floor index.
REQ-009 SHALL have port req_err, output, 1 bit: one-cycle pulse marking a rejected request.
REQ-010 SHALL have port cur_floor, output, FLOOR_W bits: the current floor.
REQ-011 SHALL have port up and port down, outputs, 1 bit each: the car is moving up or down; never both high.
REQ-012 SHALL have port stop, output, 1 bit: the car is stationary.
REQ-013 SHALL have port door, output, 1 bit: the door is open.
REQ-014 SHALL have port pending, output, NUM_FLOORS bits: the outstanding request bitmap.

Function
REQ-015 SHALL accept a request when req_valid=1 and req_floor<NUM_FLOORS; pending[req_floor] SHALL set on the next edge.
REQ-016 SHALL reject a request with req_floor>=NUM_FLOORS: pending unchanged, req_err high on the next cycle for one cycle.
REQ-017 SHALL use FSM states IDLE, MOVE_UP, MOVE_DOWN and DOOR_OPEN; stop=1 in IDLE and DOOR_OPEN; door=1 only in DOOR_OPEN.
REQ-018 SHALL, in IDLE, transition on the edge after pending becomes nonzero:
  - pending[cur_floor] set: go to DOOR_OPEN.
  - else any pending bit above cur_floor: go to MOVE_UP.
  - else: go to MOVE_DOWN.
  - tie (requests both above and below): up wins.
REQ-019 SHALL, in MOVE_UP/MOVE_DOWN, count TRAVEL_CYCLES, then increment/decrement cur_floor by 1 and reload the counter.
REQ-020 SHALL, on reaching a floor whose pending bit is set, clear that bit and enter DOOR_OPEN on the same edge; up and down drop to 0.
REQ-021 SHALL hold door open for exactly DOOR_CYCLES cycles.
REQ-022 SHALL restart the door timer and keep pending[cur_floor] clear when a request for cur_floor arrives during DOOR_OPEN.
REQ-023 SHALL, on door timer expiry, apply SCAN:
  - continue in the previous direction if any pending bit lies beyond cur_floor in that direction.
  - else reverse if any pending bit lies the other way.
  - else go to IDLE.
REQ-024 SHALL never move cur_floor below 0 or above NUM_FLOORS-1.
REQ-025 SHALL keep a same-cycle accept and arrival-clear on different floors independent; on the same floor, the clear wins and the door timer restarts.

Reset
REQ-026 SHALL, while reset=1, asynchronously force:
  - state=IDLE, cur_floor=0, pending=0.
  - up=0, down=0, door=0, stop=1, req_err=0.
  - timers=0, last direction=up.
REQ-027 SHALL discard all pending requests on reset asserted mid-travel; the car restarts at floor 0 with no motion.

Configuration
REQ-028 SHALL, when macro LIFT_ESTOP_EN is defined, add input estop (1 bit).
  - While estop=1: next edge forces up=0, down=0, door=0, stop=1; timers freeze; cur_floor and pending retained; requests still accepted.
  - On release: resume from IDLE with SCAN direction selection.
REQ-029 SHALL, when LIFT_ESTOP_EN is undefined, have no estop port and no halt logic.

Verification
REQ-030 SHALL cover: reset, then request 25 -> up=1 for 25*TRAVEL_CYCLES cycles, cur_floor=25, door=1 for 4 cycles, then IDLE with stop=1.
REQ-031 SHALL cover: at floor 25 moving up, requests 3 and 37 -> serves 37 first, then reverses and serves 3; pending=0 at end.
REQ-032 SHALL cover: request 70 with NUM_FLOORS=64 -> req_err pulses once; pending unchanged.
REQ-033 SHALL cover: request for cur_floor while door open -> door stays open 4 cycles from that request; no motion.
REQ-034 SHALL cover: reset asserted mid-travel toward floor 10 -> outputs take reset values immediately, pending=0, cur_floor=0.
REQ-035 SHALL cover (LIFT_ESTOP_EN): estop pulsed during MOVE_UP -> up=0 during halt, cur_floor held, and the target is still reached after release.
